// File: rtl/k12a_input_conditioner_pkg.sv
// Shared types and constants for the k12a input conditioner.
// The debounce FSM state type and qualify counter width live here so every channel agrees.
package k12a_input_conditioner_pkg;

    typedef enum logic {
        DB_STABLE     = 1'b0,
        DB_QUALIFYING = 1'b1
    } debounce_state_t;

    localparam int DEBOUNCE_CNT_WIDTH = 8;

endpackage

// File: rtl/k12a_input_conditioner_debounce.sv
// One conditioned input channel: synchroniser chain, polarity fix, and tick-paced debounce FSM.
// The stable output only flips after STABLE_TICKS consecutive ticks that disagree with it.
module k12a_debounce_channel
    import k12a_input_conditioner_pkg::*;
#(
    parameter int   SYNC_STAGES  = 2,
    parameter int   STABLE_TICKS = 8,
    parameter logic RESET_LEVEL  = 1'b0,
    parameter logic INVERT       = 1'b0
) (
    input  logic sys_clock,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    output logic stable
);

    localparam logic [DEBOUNCE_CNT_WIDTH-1:0] CNT_LAST = DEBOUNCE_CNT_WIDTH'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0]        r_sync;
    debounce_state_t               r_state;
    debounce_state_t               w_state_nxt;
    logic [DEBOUNCE_CNT_WIDTH-1:0] r_cnt;
    logic [DEBOUNCE_CNT_WIDTH-1:0] w_cnt_nxt;
    logic                          r_stable;
    logic                          w_stable_nxt;
    logic                          w_sample;

    // The inactive raw level is preloaded so a fresh reset never looks like an edge.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_sync   <= {SYNC_STAGES{RESET_LEVEL}};
            r_state  <= DB_STABLE;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], raw};
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_stable <= w_stable_nxt;
        end
    end

    assign w_sample = r_sync[SYNC_STAGES-1] ^ INVERT;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stable_nxt = r_stable;
        if (tick) begin
            case (r_state)
                DB_STABLE: begin
                    if (w_sample != r_stable) begin
                        if (STABLE_TICKS == 1) begin
                            w_stable_nxt = w_sample;
                        end else begin
                            w_cnt_nxt   = DEBOUNCE_CNT_WIDTH'(1);
                            w_state_nxt = DB_QUALIFYING;
                        end
                    end
                end
                DB_QUALIFYING: begin
                    if (w_sample == r_stable) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = DB_STABLE;
                    end else if (r_cnt == CNT_LAST) begin
                        // cnt+1 has reached STABLE_TICKS: accept the new level.
                        w_stable_nxt = w_sample;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = DB_STABLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DB_STABLE;
                end
            endcase
        end
    end

    assign stable = r_stable;

endmodule

// File: rtl/k12a_input_conditioner.sv
// Conditions 8 switches and 8 buttons for the k12a core: shared sample-tick prescaler,
// 16 debounce channels, and registered press/release pulses for the buttons.
module k12a_input_conditioner
    import k12a_input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES       = 2,
    parameter int TICK_CYCLES       = 50000,
    parameter int STABLE_TICKS      = 8,
    parameter int BUTTON_ACTIVE_LOW = 1
) (
    input  logic       sys_clock,
    input  logic       reset,
    input  logic [7:0] raw_switches,
    input  logic [7:0] raw_buttons,
    output logic [7:0] switches,
    output logic [7:0] buttons,
    output logic [7:0] button_press,
    output logic [7:0] button_release,
    output logic       tick
);

    localparam int            PW         = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic          BTN_INV    = (BUTTON_ACTIVE_LOW != 0);

    logic [PW-1:0] r_presc;
    logic          r_tick;
    logic [7:0]    w_switches;
    logic [7:0]    w_buttons;
    logic [7:0]    r_buttons_d;
    logic [7:0]    r_press;
    logic [7:0]    r_release;

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_presc     <= '0;
            r_tick      <= 1'b0;
            r_buttons_d <= '0;
            r_press     <= '0;
            r_release   <= '0;
        end else begin
            r_presc     <= (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
            r_tick      <= (r_presc == PRESC_LAST);
            // Both sides reset to 0 together, so a reset never produces a release pulse.
            r_buttons_d <= w_buttons;
            r_press     <= w_buttons & ~r_buttons_d;
            r_release   <= ~w_buttons & r_buttons_d;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_chan
        k12a_debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_LEVEL  (1'b0),
            .INVERT       (1'b0)
        ) u_switch (
            .sys_clock (sys_clock),
            .reset     (reset),
            .raw       (raw_switches[gi]),
            .tick      (r_tick),
            .stable    (w_switches[gi])
        );

        k12a_debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_LEVEL  (BTN_INV),
            .INVERT       (BTN_INV)
        ) u_button (
            .sys_clock (sys_clock),
            .reset     (reset),
            .raw       (raw_buttons[gi]),
            .tick      (r_tick),
            .stable    (w_buttons[gi])
        );
    end

    assign switches       = w_switches;
    assign buttons        = w_buttons;
    assign button_press   = r_press;
    assign button_release = r_release;
    assign tick           = r_tick;

endmodule

// File: tb/tb_k12a_input_conditioner.sv
// Bench for k12a_input_conditioner: directed scenarios plus random pin activity, with a
// tick-level reference model feeding an output-change scoreboard.
module tb_k12a_input_conditioner;

    localparam int SYNC = 2;
    localparam int TICK = 4;
    localparam int ST   = 3;

    logic       sys_clock;
    logic       reset;
    logic [7:0] raw_switches;
    logic [7:0] raw_buttons;
    logic [7:0] switches;
    logic [7:0] buttons;
    logic [7:0] button_press;
    logic [7:0] button_release;
    logic       tick;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic [32:0] v;
    } exp_t;
    exp_t sb[$];

    k12a_input_conditioner #(
        .SYNC_STAGES       (SYNC),
        .TICK_CYCLES       (TICK),
        .STABLE_TICKS      (ST),
        .BUTTON_ACTIVE_LOW (1)
    ) dut (
        .sys_clock      (sys_clock),
        .reset          (reset),
        .raw_switches   (raw_switches),
        .raw_buttons    (raw_buttons),
        .switches       (switches),
        .buttons        (buttons),
        .button_press   (button_press),
        .button_release (button_release),
        .tick           (tick)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    // Reference model: counts posedges since reset release (k), remembers the raw pins seen
    // at each edge, and on every tick counts consecutive ticks that disagree with the level.
    initial begin : model
        int          k;
        int          dsw [8];
        int          dbt [8];
        logic [7:0]  lsw, lbt, lbt_old, press, rel, psw, pbt;
        logic        mtick, eval;
        logic [7:0]  hsw [16];
        logic [7:0]  hbt [16];
        logic [32:0] pred, pred_prev;
        k = 0; lsw = '0; lbt = '0; lbt_old = '0; press = '0; rel = '0;
        mtick = 1'b0; pred_prev = '0;
        for (int i = 0; i < 8; i++) begin dsw[i] = 0; dbt[i] = 0; end
        forever begin
            @(posedge sys_clock);
            cyc++;
            if (reset) begin
                k = 0; lsw = '0; lbt = '0; lbt_old = '0; press = '0; rel = '0; mtick = 1'b0;
                for (int i = 0; i < 8; i++) begin dsw[i] = 0; dbt[i] = 0; end
            end else begin
                k++;
                hsw[k % 16] = raw_switches;
                hbt[k % 16] = raw_buttons;
                eval    = mtick;
                press   = lbt & ~lbt_old;
                rel     = ~lbt & lbt_old;
                lbt_old = lbt;
                if (eval) begin
                    if (k - SYNC >= 1) begin
                        psw = hsw[(k - SYNC) % 16];
                        pbt = ~hbt[(k - SYNC) % 16];
                    end else begin
                        psw = '0;
                        pbt = '0;
                    end
                    for (int i = 0; i < 8; i++) begin
                        if (psw[i] != lsw[i]) begin
                            dsw[i]++;
                            if (dsw[i] == ST) begin lsw[i] = ~lsw[i]; dsw[i] = 0; end
                        end else dsw[i] = 0;
                        if (pbt[i] != lbt[i]) begin
                            dbt[i]++;
                            if (dbt[i] == ST) begin lbt[i] = ~lbt[i]; dbt[i] = 0; end
                        end else dbt[i] = 0;
                    end
                end
                mtick = (k % TICK == 0);
            end
            pred = {mtick, rel, press, lbt, lsw};
            if (pred !== pred_prev) sb.push_back('{cyc: cyc, v: pred});
            pred_prev = pred;
        end
    end

    // Monitor: every change of the DUT outputs must match the next predicted change.
    initial begin : monitor
        logic [32:0] prev, cur;
        exp_t        e;
        prev = '0;
        @(posedge sys_clock);
        forever begin
            @(negedge sys_clock);
            cur = {tick, button_release, button_press, buttons, switches};
            if (cur !== prev) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected cyc=%0d got=%h required=no_change", cyc, cur);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.v !== cur) begin
                        failures++;
                        $display("FAIL sb_event cyc=%0d got=%h required cyc=%0d val=%h",
                                 cyc, cur, e.cyc, e.v);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic chk_range(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic wait_for(input logic [7:0] bm, input logic [7:0] bv, input logic [7:0] sm,
                            input logic [7:0] sv, input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge sys_clock);
            if (((buttons & bm) == bv) && ((switches & sm) == sv)) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin : stim
        int   n;
        logic dirty;
        logic found;
        reset = 1'b1; raw_buttons = 8'hFF; raw_switches = 8'h00;
        repeat (3) @(negedge sys_clock);
        chk("reset_outputs", {button_release, button_press, buttons, switches, 7'd0, tick}, 32'h0);
        reset = 1'b0;

        // Reset behaviour and first tick position.
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge sys_clock);
            if (tick === 1'b1) begin n = i; break; end
        end
        chk("first_tick", n, 4);
        dirty = 1'b0;
        repeat (96) begin
            @(negedge sys_clock);
            if ({button_release, button_press, buttons, switches} !== 32'h0) dirty = 1'b1;
        end
        chk("idle_after_reset", dirty, 1'b0);

        // Clean press on button 3.
        raw_buttons[3] = 1'b0;
        wait_for(8'h08, 8'h08, 8'h00, 8'h00, 40, n);
        chk_range("press_latency", n, 11, 17);
        chk("press_levels", {buttons, switches}, 16'h0800);
        @(negedge sys_clock);
        chk("press_pulse", {button_press, button_release}, 16'h0800);
        @(negedge sys_clock);
        chk("press_pulse_end", {button_press, button_release}, 16'h0000);

        // Glitch on switch 0 lasting two ticks.
        raw_switches[0] = 1'b1;
        repeat (8) @(negedge sys_clock);
        raw_switches[0] = 1'b0;
        repeat (40) @(negedge sys_clock);
        chk("glitch_rejected", switches, 8'h00);

        // Release of button 3.
        raw_buttons[3] = 1'b1;
        wait_for(8'h08, 8'h00, 8'h00, 8'h00, 40, n);
        chk_range("release_latency", n, 11, 17);
        @(negedge sys_clock);
        chk("release_pulse", {button_press, button_release}, 16'h0008);
        @(negedge sys_clock);
        chk("release_pulse_end", {button_press, button_release}, 16'h0000);

        // All channels change together.
        repeat (5) @(negedge sys_clock);
        raw_switches = 8'hA5; raw_buttons = 8'h00;
        wait_for(8'h01, 8'h01, 8'h00, 8'h00, 40, n);
        chk_range("multi_latency", n, 11, 17);
        chk("multi_levels", {buttons, switches}, 16'hFFA5);
        @(negedge sys_clock);
        chk("multi_press", button_press, 8'hFF);

        // Reset just before the third qualifying tick of button 0.
        raw_switches = 8'h00; raw_buttons = 8'hFF;
        repeat (40) @(negedge sys_clock);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clock);
            if (tick === 1'b1) begin found = 1'b1; break; end
        end
        chk("align_tick", found, 1'b1);
        raw_buttons[0] = 1'b0;
        repeat (11) @(negedge sys_clock);
        reset = 1'b1;
        repeat (2) @(negedge sys_clock);
        reset = 1'b0;
        chk("midreset_levels", {button_press, button_release, buttons}, 24'h0);
        wait_for(8'h01, 8'h01, 8'h00, 8'h00, 40, n);
        chk("midreset_restart", n, 13);
        @(negedge sys_clock);
        chk("midreset_press", button_press, 8'h01);

        // Random pin activity with occasional resets.
        repeat (3000) begin
            @(negedge sys_clock);
            n = $urandom_range(0, 99);
            if (n < 3) raw_switches[$urandom_range(0, 7)] ^= 1'b1;
            else if (n < 6) raw_buttons[$urandom_range(0, 7)] ^= 1'b1;
            reset = ($urandom_range(0, 499) == 0);
        end
        reset = 1'b0;
        repeat (60) @(negedge sys_clock);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
